// File: rtl/convolution_fsm.sv
// Convolution pass sequencer: times row traversals, pulses shift_row_up per row boundary, then conv_done after tree drain.
// Optional registered busy output when CONV_FSM_BUSY_EN is defined.
module convolution_fsm #(
  parameter int P_SR_DEPTH    = 2,
  parameter int RAM_SR_DEPTH  = 4,
  parameter int NUM_SR_ROWS   = 4,
  parameter int MA_TREE_SIZE  = 16,
  parameter int MA_TREE_DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic input_start,
  output logic shift_row_up,
  output logic conv_done
`ifdef CONV_FSM_BUSY_EN
  ,
  output logic busy
`endif
);

  localparam int CW = $clog2(RAM_SR_DEPTH + 1);
  localparam int RW = $clog2(NUM_SR_ROWS + 1);
  localparam int DW = $clog2(MA_TREE_DEPTH + 1);

  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_LAST = CW'(RAM_SR_DEPTH);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(NUM_SR_ROWS - 1);
  localparam logic [DW-1:0] DRN_ONE  = DW'(1);
  localparam logic [DW-1:0] DRN_LAST = DW'(MA_TREE_DEPTH);

  localparam bit CFG_OK = (P_SR_DEPTH >= 1) && (RAM_SR_DEPTH >= 1) && (NUM_SR_ROWS >= 1) &&
                          (MA_TREE_DEPTH >= 1) && (MA_TREE_SIZE >= 1);

  generate
    if (!CFG_OK) begin : g_cfg_err
      $error("convolution_fsm: all depth/size parameters must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_cnt_q, col_cnt_d;
  logic [RW-1:0]   row_cnt_q, row_cnt_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic            shift_row_up_q, shift_row_up_d;
  logic            conv_done_q, conv_done_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      col_cnt_q      <= '0;
      row_cnt_q      <= '0;
      drain_cnt_q    <= '0;
      shift_row_up_q <= 1'b0;
      conv_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_cnt_q      <= col_cnt_d;
      row_cnt_q      <= row_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      shift_row_up_q <= shift_row_up_d;
      conv_done_q    <= conv_done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    col_cnt_d      = col_cnt_q;
    row_cnt_d      = row_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    shift_row_up_d = 1'b0;
    conv_done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (input_start) begin
          // A single-row array has no boundaries to cross, so only the tree latency remains.
          if (NUM_SR_ROWS == 1) begin
            state_d     = DRAIN;
            drain_cnt_d = DRN_ONE;
          end else begin
            state_d   = SHIFT;
            col_cnt_d = COL_ONE;
            row_cnt_d = ROW_ONE;
          end
        end
      end

      SHIFT: begin
        if (col_cnt_q == COL_LAST) begin
          shift_row_up_d = 1'b1;
          col_cnt_d      = COL_ONE;
          row_cnt_d      = row_cnt_q + ROW_ONE;
          if (row_cnt_q == ROW_LAST) begin
            state_d     = DRAIN;
            drain_cnt_d = DRN_ONE;
          end
        end else begin
          col_cnt_d = col_cnt_q + COL_ONE;
        end
      end

      DRAIN: begin
        if (drain_cnt_q == DRN_LAST) begin
          conv_done_d = 1'b1;
          state_d     = IDLE;
          col_cnt_d   = '0;
          row_cnt_d   = '0;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + DRN_ONE;
        end
      end

      default: begin
        state_d     = IDLE;
        col_cnt_d   = '0;
        row_cnt_d   = '0;
        drain_cnt_d = '0;
      end
    endcase
  end

  assign shift_row_up = shift_row_up_q;
  assign conv_done    = conv_done_q;

`ifdef CONV_FSM_BUSY_EN
  logic busy_q;

  // Driven from the next state so busy rises in the first SHIFT/DRAIN cycle and drops with conv_done.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
    end
  end

  assign busy = busy_q;
`endif

endmodule

// File: tb/tb_convolution_fsm.sv
// Directed bench for convolution_fsm: default config table plus small-parameter and held-start sequences.
module tb_convolution_fsm;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst0, st0, sru0, done0;
  logic rst12, st1, sru1, done1, st2, sru2, done2;
`ifdef CONV_FSM_BUSY_EN
  logic busy0, busy1, busy2;
`endif

  convolution_fsm u_dut0 (
    .clock(clock), .reset(rst0), .input_start(st0),
    .shift_row_up(sru0), .conv_done(done0)
`ifdef CONV_FSM_BUSY_EN
    , .busy(busy0)
`endif
  );

  convolution_fsm #(.NUM_SR_ROWS(1), .MA_TREE_DEPTH(3)) u_dut1 (
    .clock(clock), .reset(rst12), .input_start(st1),
    .shift_row_up(sru1), .conv_done(done1)
`ifdef CONV_FSM_BUSY_EN
    , .busy(busy1)
`endif
  );

  convolution_fsm #(.RAM_SR_DEPTH(1), .NUM_SR_ROWS(3), .MA_TREE_DEPTH(1)) u_dut2 (
    .clock(clock), .reset(rst12), .input_start(st2),
    .shift_row_up(sru2), .conv_done(done2)
`ifdef CONV_FSM_BUSY_EN
    , .busy(busy2)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic rst;
    logic start;
    logic sru;
    logic done;
  } vec_t;

  localparam int NVEC = 71;
  vec_t vec [NVEC];

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
  endtask

  initial begin
    rst0 = 1'b1; st0 = 1'b0; rst12 = 1'b1; st1 = 1'b0; st2 = 1'b0;

    // Default config: entry i drives inputs sampled at edge E_i, expects outputs after E_i.
    for (int i = 0; i < NVEC; i++) vec[i] = '{rst: 1'b0, start: 1'b0, sru: 1'b0, done: 1'b0};
    vec[0].rst = 1'b1;
    vec[1].rst = 1'b1; vec[1].start = 1'b1;   // reset beats start
    vec[3].start = 1'b1;                      // S = E3
    vec[7].sru = 1'b1; vec[11].sru = 1'b1; vec[15].sru = 1'b1;
    vec[19].done = 1'b1;                      // quiet through S+20 = E23
    vec[24].start = 1'b1;                     // S' = E24
    vec[28].sru = 1'b1;
    vec[30].rst = 1'b1; vec[30].start = 1'b1; // abort at S'+6
    vec[34].start = 1'b1;                     // restart at S'+10
    vec[38].sru = 1'b1; vec[42].sru = 1'b1; vec[46].sru = 1'b1;
    vec[40].start = 1'b1;                     // ignored in SHIFT
    vec[48].start = 1'b1;                     // ignored in DRAIN
    vec[50].done = 1'b1;
    vec[51].start = 1'b1;                     // sampled in the conv_done cycle
    vec[55].sru = 1'b1; vec[59].sru = 1'b1; vec[63].sru = 1'b1;
    vec[67].done = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      rst0  = vec[i].rst;
      st0   = vec[i].start;
      rst12 = (i < 2);
      @(posedge clock);
      @(negedge clock);
      chk("tbl_sru", i, sru0, vec[i].sru);
      chk("tbl_done", i, done0, vec[i].done);
`ifdef CONV_FSM_BUSY_EN
      if (i == 0) chk("busy_rst", i, busy0, 1'b0);
`endif
    end

    // Start held high: runs repeat every R*(N-1)+M+1 = 17 edges; release after edge S+40.
    for (int k = 0; k <= 56; k++) begin
      logic esru, edone;
      st0 = (k <= 40);
      @(posedge clock);
      @(negedge clock);
      esru  = (k <= 50) && ((k % 17) == 4 || (k % 17) == 8 || (k % 17) == 12);
      edone = (k <= 50) && ((k % 17) == 16);
      chk("hold_sru", k, sru0, esru);
      chk("hold_done", k, done0, edone);
    end
    st0 = 1'b0;

    // N=1,M=3 and R=1,N=3,M=1 started on the same edge.
    for (int k = 0; k <= 6; k++) begin
      st1 = (k == 0);
      st2 = (k == 0);
      @(posedge clock);
      @(negedge clock);
      chk("n1_sru", k, sru1, 1'b0);
      chk("n1_done", k, done1, (k == 3));
      chk("r1_sru", k, sru2, (k == 1 || k == 2));
      chk("r1_done", k, done2, (k == 3));
    end
    st1 = 1'b0;
    st2 = 1'b0;

`ifdef CONV_FSM_BUSY_EN
    for (int k = 0; k <= 20; k++) begin
      st0 = (k == 0);
      @(posedge clock);
      @(negedge clock);
      chk("busy", k, busy0, (k <= 15));
      chk("busy_done", k, done0, (k == 16));
    end
    st0 = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
